// File: rtl/washing_machine_pkg.sv
// Shared definitions for the washing machine controller: state encoding and
// the state-to-actuator one-hot decode.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package washing_machine_pkg;

  localparam int unsigned NUM_PHASES = 8;

  // Encoding is fixed; every 3-bit value names a state. The bit index of each
  // state in the one-hot output vector equals its encoding.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SOAK_LOW  = 3'd1,
    ST_SOAK_HIGH = 3'd2,
    ST_WASH_LOW  = 3'd3,
    ST_WASH_HIGH = 3'd4,
    ST_DRAIN     = 3'd5,
    ST_RINSE     = 3'd6,
    ST_SPIN      = 3'd7
  } state_t;

  // Output vector order (msb..lsb):
  // spin, rinse, drain, wash_high, wash_low, soak_high, soak_low, idle
  function automatic logic [NUM_PHASES-1:0] state_onehot(input state_t s);
    logic [NUM_PHASES-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/washing_machine.sv
// Moore FSM sequencing a two-program wash cycle from front-panel inputs and
// external per-phase timer-done strobes; outputs are one-hot actuator enables.
// Latency: one clock from qualifying input to new output. Backpressure: none;
// every input is sampled each cycle, a phase holds until its own timer fires.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, select     begin cycle / program (1 = high load), sampled in IDLE only
//   stop              abort to IDLE from any state
//   timer_*           phase-done inputs, each honoured only in its own phase
//   idle..drain       one-hot phase outputs, decoded from state only
module washing_machine
  import washing_machine_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic select,
  input  logic stop,
  input  logic timer_soak_low,
  input  logic timer_soak_high,
  input  logic timer_wash_low,
  input  logic timer_wash_high,
  input  logic timer_spin,
  input  logic timer_rinse,
  input  logic timer_drain,
  output logic idle,
  output logic soak_low,
  output logic soak_high,
  output logic wash_low,
  output logic wash_high,
  output logic rinse,
  output logic spin,
  output logic drain
);

  state_t r_state;
  logic   r_mode;
  state_t w_state_nxt;
  logic   w_mode_nxt;
  logic [NUM_PHASES-1:0] w_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    if (stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_mode_nxt  = select;
            w_state_nxt = select ? ST_SOAK_HIGH : ST_SOAK_LOW;
          end
        end
        // Program-specific phases cross-check the latched mode: a state that
        // disagrees with it can only come from corruption, so bail to IDLE.
        ST_SOAK_LOW: begin
          if (r_mode)              w_state_nxt = ST_IDLE;
          else if (timer_soak_low) w_state_nxt = ST_WASH_LOW;
        end
        ST_SOAK_HIGH: begin
          if (!r_mode)              w_state_nxt = ST_IDLE;
          else if (timer_soak_high) w_state_nxt = ST_WASH_HIGH;
        end
        ST_WASH_LOW: begin
          if (r_mode)              w_state_nxt = ST_IDLE;
          else if (timer_wash_low) w_state_nxt = ST_DRAIN;
        end
        ST_WASH_HIGH: begin
          if (!r_mode)              w_state_nxt = ST_IDLE;
          else if (timer_wash_high) w_state_nxt = ST_DRAIN;
        end
        ST_DRAIN: if (timer_drain) w_state_nxt = ST_RINSE;
        ST_RINSE: if (timer_rinse) w_state_nxt = ST_SPIN;
        ST_SPIN:  if (timer_spin)  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_onehot = state_onehot(r_state);
  assign {spin, rinse, drain, wash_high, wash_low, soak_high, soak_low, idle} = w_onehot;

endmodule

// File: tb/tb_washing_machine.sv
// Directed bench for washing_machine: program sequences, foreign timers,
// abort, mid-cycle reset and back-to-back start, plus a per-cycle one-hot check.
module tb_washing_machine;

  localparam logic [7:0] V_IDLE = 8'h01;
  localparam logic [7:0] V_SL   = 8'h02;
  localparam logic [7:0] V_SH   = 8'h04;
  localparam logic [7:0] V_WL   = 8'h08;
  localparam logic [7:0] V_WH   = 8'h10;
  localparam logic [7:0] V_DR   = 8'h20;
  localparam logic [7:0] V_RI   = 8'h40;
  localparam logic [7:0] V_SP   = 8'h80;

  // timer vector index: 0 soak_low, 1 soak_high, 2 wash_low, 3 wash_high,
  // 4 drain, 5 rinse, 6 spin
  localparam int T_SL = 0, T_SH = 1, T_WL = 2, T_WH = 3, T_DR = 4, T_RI = 5, T_SP = 6;

  logic clk = 1'b0;
  logic rst, start, select, stop;
  logic [6:0] tmr;
  logic idle, soak_low, soak_high, wash_low, wash_high, rinse, spin, drain;
  logic [7:0] obs;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  washing_machine dut (
    .clk(clk), .rst(rst), .start(start), .select(select), .stop(stop),
    .timer_soak_low(tmr[T_SL]), .timer_soak_high(tmr[T_SH]),
    .timer_wash_low(tmr[T_WL]), .timer_wash_high(tmr[T_WH]),
    .timer_spin(tmr[T_SP]), .timer_rinse(tmr[T_RI]), .timer_drain(tmr[T_DR]),
    .idle(idle), .soak_low(soak_low), .soak_high(soak_high),
    .wash_low(wash_low), .wash_high(wash_high), .rinse(rinse),
    .spin(spin), .drain(drain)
  );

  assign obs = {spin, rinse, drain, wash_high, wash_low, soak_high, soak_low, idle};

  // Exactly one phase output high on every sampled cycle once out of reset.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ($countones(obs) !== 1) begin
        n_bad++;
        $display("FAIL onehot t=%0t outputs=%b required exactly one bit set", $time, obs);
      end
    end
  end

  // Advance one edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; select = 1'b0; stop = 1'b0; tmr = '0;
    step(); step();
    n_cmp++;
    if (obs !== V_IDLE) begin
      n_bad++;
      $display("FAIL reset_state got=%b want=%b", obs, V_IDLE);
    end
    rst = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (obs !== V_IDLE) begin
        n_bad++;
        $display("FAIL idle_hold[%0d] got=%b want=%b", i, obs, V_IDLE);
      end
    end
  endtask

  task automatic test_high_program();
    int tsel [5] = '{T_SH, T_WH, T_DR, T_RI, T_SP};
    logic [7:0] exp [5] = '{V_WH, V_DR, V_RI, V_SP, V_IDLE};
    select = 1'b1; start = 1'b1;
    step();
    start = 1'b0; select = 1'b0;
    n_cmp++;
    if (obs !== V_SH) begin
      n_bad++;
      $display("FAIL high_start got=%b want=%b", obs, V_SH);
    end
    step();
    n_cmp++;
    if (obs !== V_SH) begin
      n_bad++;
      $display("FAIL high_soak_hold got=%b want=%b", obs, V_SH);
    end
    for (int i = 0; i < 5; i++) begin
      tmr[tsel[i]] = 1'b1;
      step();
      tmr = '0;
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL high_step[%0d] got=%b want=%b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_low_program();
    int tsel [5] = '{T_SL, T_WL, T_DR, T_RI, T_SP};
    logic [7:0] exp [5] = '{V_WL, V_DR, V_RI, V_SP, V_IDLE};
    select = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (obs !== V_SL) begin
      n_bad++;
      $display("FAIL low_start got=%b want=%b", obs, V_SL);
    end
    for (int i = 0; i < 5; i++) begin
      tmr[tsel[i]] = 1'b1;
      step();
      tmr = '0;
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL low_step[%0d] got=%b want=%b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_foreign_timers();
    select = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    // In SOAK_LOW the high-program soak timer must not advance it.
    tmr[T_SH] = 1'b1;
    step();
    tmr = '0;
    n_cmp++;
    if (obs !== V_SL) begin
      n_bad++;
      $display("FAIL foreign_soak got=%b want=%b", obs, V_SL);
    end
    tmr[T_SL] = 1'b1;
    step();
    tmr = '0;
    // WASH_LOW: select toggles and start pulses are ignored.
    for (int i = 0; i < 3; i++) begin
      select = ~select;
      start = (i == 1);
      step();
      n_cmp++;
      if (obs !== V_WL) begin
        n_bad++;
        $display("FAIL wash_select_toggle[%0d] got=%b want=%b", i, obs, V_WL);
      end
    end
    start = 1'b0; select = 1'b0;
    tmr[T_WL] = 1'b1; step(); tmr = '0;
    tmr[T_DR] = 1'b1; step(); tmr = '0;
    n_cmp++;
    if (obs !== V_RI) begin
      n_bad++;
      $display("FAIL reach_rinse got=%b want=%b", obs, V_RI);
    end
    tmr[T_DR] = 1'b1; tmr[T_WH] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (obs !== V_RI) begin
        n_bad++;
        $display("FAIL rinse_foreign[%0d] got=%b want=%b", i, obs, V_RI);
      end
    end
    tmr = '0;
    tmr[T_RI] = 1'b1; step(); tmr = '0;
    tmr[T_SP] = 1'b1; step(); tmr = '0;
    n_cmp++;
    if (obs !== V_IDLE) begin
      n_bad++;
      $display("FAIL foreign_end got=%b want=%b", obs, V_IDLE);
    end
  endtask

  task automatic test_abort();
    select = 1'b1; start = 1'b1;
    step();
    start = 1'b0; select = 1'b0;
    tmr[T_SH] = 1'b1; step(); tmr = '0;
    tmr[T_WH] = 1'b1; step(); tmr = '0;
    n_cmp++;
    if (obs !== V_DR) begin
      n_bad++;
      $display("FAIL abort_reach_drain got=%b want=%b", obs, V_DR);
    end
    stop = 1'b1;
    tmr[T_DR] = 1'b1;
    step();
    tmr = '0;
    n_cmp++;
    if (obs !== V_IDLE) begin
      n_bad++;
      $display("FAIL abort_drain got=%b want=%b", obs, V_IDLE);
    end
    start = 1'b1; select = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (obs !== V_IDLE) begin
        n_bad++;
        $display("FAIL stop_with_start[%0d] got=%b want=%b", i, obs, V_IDLE);
      end
    end
    stop = 1'b0; start = 1'b0; select = 1'b0;
  endtask

  task automatic test_reset_mid_cycle();
    select = 1'b1; start = 1'b1;
    step();
    start = 1'b0; select = 1'b0;
    tmr[T_SH] = 1'b1; step(); tmr = '0;
    n_cmp++;
    if (obs !== V_WH) begin
      n_bad++;
      $display("FAIL rst_mid_reach_wash got=%b want=%b", obs, V_WH);
    end
    rst = 1'b1; tmr[T_WH] = 1'b1;
    step();
    rst = 1'b0; tmr = '0;
    n_cmp++;
    if (obs !== V_IDLE) begin
      n_bad++;
      $display("FAIL rst_mid_cycle got=%b want=%b", obs, V_IDLE);
    end
    // Reset cleared mode: a low start must run the low program.
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (obs !== V_SL) begin
      n_bad++;
      $display("FAIL after_rst_low got=%b want=%b", obs, V_SL);
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    select = 1'b0; start = 1'b1;
    step();
    tmr[T_SL] = 1'b1; step(); tmr = '0;
    tmr[T_WL] = 1'b1; step(); tmr = '0;
    tmr[T_DR] = 1'b1; step(); tmr = '0;
    tmr[T_RI] = 1'b1; step(); tmr = '0;
    n_cmp++;
    if (obs !== V_SP) begin
      n_bad++;
      $display("FAIL b2b_spin got=%b want=%b", obs, V_SP);
    end
    tmr[T_SP] = 1'b1; step(); tmr = '0;
    n_cmp++;
    if (obs !== V_IDLE) begin
      n_bad++;
      $display("FAIL b2b_idle got=%b want=%b", obs, V_IDLE);
    end
    select = 1'b1;
    step();
    n_cmp++;
    if (obs !== V_SH) begin
      n_bad++;
      $display("FAIL b2b_restart got=%b want=%b", obs, V_SH);
    end
    start = 1'b0; select = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++;
    if (obs !== V_IDLE) begin
      n_bad++;
      $display("FAIL b2b_stop got=%b want=%b", obs, V_IDLE);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; select = 1'b0; stop = 1'b0; tmr = '0;
    test_reset();
    test_high_program();
    test_low_program();
    test_foreign_timers();
    test_abort();
    test_reset_mid_cycle();
    test_back_to_back();
    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/washing_machine.md
Name: washing_machine

Overview:
- Moore FSM controller for a two-program (low/high load) washing cycle.
- Sequence: idle -> soak -> wash -> drain -> rinse -> spin -> idle.
- Phase ends are signalled by external per-phase timer-done inputs; the block owns no counters.
- Sits between the front-panel inputs (start/select/stop) and the actuator drivers (one-hot phase outputs).

Parameters:
- None. State encoding is fixed in the shared package.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a cycle; level, sampled only in IDLE.
- select  in  1  program select: 1 = high load, 0 = low load; sampled with start.
- stop  in  1  abort; level, sampled every cycle.
- timer_soak_low  in  1  soak-low phase done.
- timer_soak_high  in  1  soak-high phase done.
- timer_wash_low  in  1  wash-low phase done.
- timer_wash_high  in  1  wash-high phase done.
- timer_spin  in  1  spin phase done.
- timer_rinse  in  1  rinse phase done.
- timer_drain  in  1  drain phase done.
- idle  out  1  machine idle.
- soak_low  out  1  soaking, low program.
- soak_high  out  1  soaking, high program.
- wash_low  out  1  washing, low program.
- wash_high  out  1  washing, high program.
- rinse  out  1  rinsing.
- spin  out  1  spinning.
- drain  out  1  draining.

Behaviour:
- One clock; reset is synchronous and active-high, on port rst sampled at the rising edge of clk.
- States: IDLE, SOAK_LOW, SOAK_HIGH, WASH_LOW, WASH_HIGH, DRAIN, RINSE, SPIN. One state register; outputs decoded from state only (Moore).
- Output invariant: exactly one output high at all times, matching its state.
- Reset: state = IDLE, mode = 0. idle = 1, all other outputs = 0 the cycle after the rst edge.
- Priority at each edge: rst > stop > normal transition.
- IDLE: if start = 1 and stop = 0, latch mode <= select and go to SOAK_HIGH (select = 1) or SOAK_LOW (select = 0). Otherwise stay in IDLE.
- SOAK_LOW: timer_soak_low = 1 -> WASH_LOW; else hold.
- SOAK_HIGH: timer_soak_high = 1 -> WASH_HIGH; else hold.
- WASH_LOW: timer_wash_low = 1 -> DRAIN; else hold.
- WASH_HIGH: timer_wash_high = 1 -> DRAIN; else hold.
- DRAIN: timer_drain = 1 -> RINSE; else hold.
- RINSE: timer_rinse = 1 -> SPIN; else hold.
- SPIN: timer_spin = 1 -> IDLE; else hold.
- Latency: one clock from qualifying input to new output.
- Each state honours only its own timer. Other timers are ignored, even if held high (e.g. timer_drain = 1 during RINSE has no effect).
- A timer held high therefore advances exactly one phase.
- start and select are ignored outside IDLE. The program cannot change mid-cycle; mode is latched for debug and selection only.
- stop = 1 in any non-IDLE state -> IDLE next cycle.
- stop = 1 with start = 1 in IDLE -> stay IDLE.
- rst mid-cycle -> IDLE next cycle, regardless of other inputs.
- After SPIN -> IDLE: if start is still high, a new cycle begins on the following edge (start is level-sensitive).
- Illegal or unreachable state encodings recover to IDLE.

Decomposition:
- Package washing_machine_pkg: state enum (8 values, 3-bit); a function mapping state to the 8-bit one-hot output vector.
- No sub-module. Implement as a single FSM module: next-state block, state/mode register, output decode.

Test Plan:
- Reset: rst = 1 for 2 cycles, all other inputs 0 -> idle = 1, others 0. Hold start = 0 for 5 cycles -> idle stays 1.
- High program: select = 1, start = 1; then pulse timer_soak_high, timer_wash_high, timer_drain, timer_rinse, timer_spin, each for one cycle when its phase is active. Required output sequence, one step per pulse: soak_high -> wash_high -> drain -> rinse -> spin -> idle.
- Low program: select = 0, start = 1; pulse timer_soak_low, timer_wash_low, timer_drain, timer_rinse, timer_spin -> soak_low -> wash_low -> drain -> rinse -> spin -> idle.
- Foreign timers: in RINSE, hold timer_drain = 1 and timer_wash_high = 1 for 4 cycles -> rinse stays 1. In WASH_LOW, toggle select -> wash_low unchanged.
- Abort: stop = 1 for one cycle during DRAIN -> idle = 1 next cycle. Same cycle, start = 1 with stop = 1 in IDLE -> remains idle.
- Reset mid-cycle: rst = 1 during WASH_HIGH with timer_wash_high = 1 -> idle = 1 next cycle, not drain. Also confirm at every sampled cycle of all scenarios that exactly one output is high.
